// File: rtl/cp0_timer_irq.sv
// Count/Compare timer and interrupt-pending unit carved out of CP0.
// Owns Count, Compare, Cause.TI and Cause.IP; produces a masked, prioritised interrupt request.
module cp0_timer_irq #(
  parameter int unsigned N_HW_INT    = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TI_LINE     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_HW_INT-1:0] hw_int,
  input  logic                w_ena,
  input  logic [7:0]          w_addr,
  input  logic [31:0]         w_data,
  input  logic [7:0]          r_addr,
  output logic [31:0]         r_data,
  output logic                r_hit,
  input  logic [7:0]          status_im,
  input  logic                status_ie,
  input  logic                status_exl,
  output logic [7:0]          cause_ip,
  output logic                cause_ti,
  output logic                int_req,
  output logic [2:0]          int_num
);

  localparam int unsigned DivW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [7:0]  AddrCount   = 8'h48;  // {9,0}
  localparam logic [7:0]  AddrCompare = 8'h58;  // {11,0}
  localparam logic [7:0]  AddrCause   = 8'h68;  // {13,0}

  logic [31:0]         count_q, count_d;
  logic [31:0]         compare_q, compare_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                ti_q, ti_d;
  logic                match_q, match_d;
  logic [1:0]          ip_sw_q, ip_sw_d;
  logic [N_HW_INT-1:0] sync_q [SYNC_STAGES];

  logic        wr_count, wr_compare, wr_cause, tick;
  logic [31:0] count_inc;
  logic [7:0]  pend;

  always_comb begin
    wr_count   = w_ena && (w_addr == AddrCount);
    wr_compare = w_ena && (w_addr == AddrCompare);
    wr_cause   = w_ena && (w_addr == AddrCause);
    tick       = (div_q == DivW'(COUNT_DIV - 1));
    count_inc  = count_q + 32'd1;

    count_d = count_q;
    div_d   = div_q + DivW'(1);
    match_d = 1'b0;
    if (wr_count) begin
      count_d = w_data;
      div_d   = '0;
    end else if (tick) begin
      count_d = count_inc;
      div_d   = '0;
      // Match is flagged now and lands in TI next cycle; a Compare write cancels it.
      match_d = (count_inc == compare_q) && !wr_compare;
    end

    compare_d = wr_compare ? w_data : compare_q;
    ti_d      = wr_compare ? 1'b0 : (ti_q | match_q);
    ip_sw_d   = wr_cause ? w_data[9:8] : ip_sw_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      div_q     <= '0;
      ti_q      <= 1'b0;
      match_q   <= 1'b0;
      ip_sw_q   <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      div_q     <= div_d;
      ti_q      <= ti_d;
      match_q   <= match_d;
      ip_sw_q   <= ip_sw_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    cause_ip      = '0;
    cause_ip[1:0] = ip_sw_q;
    for (int unsigned i = 0; i < N_HW_INT; i++) cause_ip[2+i] = sync_q[SYNC_STAGES-1][i];
    cause_ip[TI_LINE] = cause_ip[TI_LINE] | ti_q;
    cause_ti = ti_q;

    pend    = cause_ip & status_im;
    int_req = (|pend) && status_ie && !status_exl;
    int_num = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend[i]) int_num = 3'(i);
    end
  end

  always_comb begin
    r_data = '0;
    r_hit  = 1'b1;
    case (r_addr)
      AddrCount:   r_data = count_q;
      AddrCompare: r_data = compare_q;
      AddrCause:   r_data = {1'b0, ti_q, 14'b0, cause_ip, 8'b0};
      default:     r_hit  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Bench for cp0_timer_irq: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_cp0_timer_irq;

  localparam int unsigned NHw    = 6;
  localparam int unsigned Div    = 2;
  localparam int unsigned Sync   = 2;
  localparam int unsigned TiLine = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NHw-1:0] hw_int = '0;
  logic           w_ena = 1'b0;
  logic [7:0]     w_addr = '0;
  logic [31:0]    w_data = '0;
  logic [7:0]     r_addr = 8'h48;
  logic [31:0]    r_data;
  logic           r_hit;
  logic [7:0]     status_im = 8'hFF;
  logic           status_ie = 1'b1;
  logic           status_exl = 1'b0;
  logic [7:0]     cause_ip;
  logic           cause_ti;
  logic           int_req;
  logic [2:0]     int_num;

  int n_vec = 0;
  int n_err = 0;

  cp0_timer_irq #(
    .N_HW_INT   (NHw),
    .COUNT_DIV  (Div),
    .SYNC_STAGES(Sync),
    .TI_LINE    (TiLine)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hw_int    (hw_int),
    .w_ena     (w_ena),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .r_hit     (r_hit),
    .status_im (status_im),
    .status_ie (status_ie),
    .status_exl(status_exl),
    .cause_ip  (cause_ip),
    .cause_ti  (cause_ti),
    .int_req   (int_req),
    .int_num   (int_num)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural values plus a delay line of hw_int samples.
  bit [31:0]    m_count, m_cmp;
  bit           m_ti, m_pend;
  int           m_phase;
  bit [1:0]     m_sw;
  bit [NHw-1:0] m_hist[$];

  task automatic m_reset();
    m_count = 0; m_cmp = 0; m_ti = 0; m_pend = 0; m_phase = 0; m_sw = 0;
    m_hist.delete();
    for (int s = 0; s < Sync; s++) m_hist.push_back('0);
  endtask

  function automatic logic [7:0] m_ip();
    logic [7:0] ip = '0;
    ip[1:0] = m_sw;
    for (int i = 0; i < NHw; i++) ip[2+i] = m_hist[Sync-1][i];
    ip[TiLine] = ip[TiLine] | m_ti;
    return ip;
  endfunction

  function automatic logic [31:0] m_rd(logic [7:0] a);
    case (a)
      8'h48:   return m_count;
      8'h58:   return m_cmp;
      8'h68:   return {1'b0, m_ti, 14'b0, m_ip(), 8'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge();
    bit        wc, wm, wk, np;
    bit [31:0] nxt;
    wc = w_ena && (w_addr == 8'h48);
    wm = w_ena && (w_addr == 8'h58);
    wk = w_ena && (w_addr == 8'h68);
    np = 0;
    if (wm) m_ti = 0;
    else if (m_pend) m_ti = 1;
    if (wc) begin
      m_count = w_data; m_phase = 0;
    end else if (m_phase == Div - 1) begin
      nxt = m_count + 1; m_count = nxt; m_phase = 0;
      np = (nxt == m_cmp) && !wm;
    end else begin
      m_phase++;
    end
    m_pend = np;
    if (wm) m_cmp = w_data;
    if (wk) m_sw = w_data[9:8];
    m_hist.push_front(hw_int);
    void'(m_hist.pop_back());
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] ip, pend;
    logic [2:0] num;
    ip   = m_ip();
    pend = ip & status_im;
    num  = '0;
    for (int i = 0; i < 8; i++) if (pend[i]) num = 3'(i);
    check("r_data",   r_data,   m_rd(r_addr));
    check("r_hit",    r_hit,    (r_addr == 8'h48) || (r_addr == 8'h58) || (r_addr == 8'h68));
    check("cause_ip", cause_ip, ip);
    check("cause_ti", cause_ti, m_ti);
    check("int_req",  int_req,  (|pend) && status_ie && !status_exl);
    check("int_num",  int_num,  num);
  endtask

  // Called at a negedge with inputs set; compares, advances one clock, returns at next negedge.
  task automatic step();
    if (!rst) m_reset();
    #1;
    check_all();
    @(posedge clk);
    if (rst) m_edge();
    else m_reset();
    @(negedge clk);
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    w_ena = 1'b1; w_addr = a; w_data = d;
    step();
    w_ena = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    repeat (3) step();
    check("rst_ip", cause_ip, 8'h00);
    check("rst_req", int_req, 1'b0);
    check("rst_count", r_data, 32'd0);

    rst = 1'b1;
    repeat (10) step();
    check("count_after_10", r_data, 32'd5);

    // Mid-count reset clears state immediately.
    step();
    rst = 1'b0;
    m_reset();
    #1;
    check("midrst_count", r_data, 32'd0);
    check("midrst_num", int_num, 3'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_count0", r_data, 32'd0);
    step();
    check("post_rst_count1", r_data, 32'd1);
    repeat (8) step();
    check("count_5_again", r_data, 32'd5);

    step();                            // odd phase
    wr(8'h48, 32'd7);
    check("cnt_wr_7", r_data, 32'd7);
    step();
    check("cnt_wr_hold", r_data, 32'd7);
    step();
    check("cnt_wr_8", r_data, 32'd8);

    wr(8'h58, 32'd3);
    wr(8'h48, 32'd0);
    repeat (6) step();
    check("cmp_count3", r_data, 32'd3);
    check("cmp_ti_pre", cause_ti, 1'b0);
    step();
    check("cmp_ti_set", cause_ti, 1'b1);
    check("cmp_ip7", cause_ip[7], 1'b1);

    wr(8'h58, 32'd3);
    wr(8'h48, 32'd0);
    repeat (5) step();
    check("clr_count2", r_data, 32'd2);
    wr(8'h58, 32'd3);
    check("clr_count3", r_data, 32'd3);
    check("clr_ti0", cause_ti, 1'b0);
    repeat (2) step();
    check("clr_ti_stays0", cause_ti, 1'b0);

    wr(8'h58, 32'd0);
    wr(8'h48, 32'hFFFF_FFFF);
    step();
    check("wrap_ffff", r_data, 32'hFFFF_FFFF);
    step();
    check("wrap_zero", r_data, 32'd0);
    check("wrap_ti_pre", cause_ti, 1'b0);
    step();
    check("wrap_ti", cause_ti, 1'b1);

    hw_int = '0;
    repeat (3) step();
    hw_int = 6'b000001;
    step();
    check("hw_lat1", cause_ip[2], 1'b0);
    step();
    check("hw_lat2", cause_ip[2], 1'b1);
    hw_int = '0;
    repeat (3) step();
    hw_int = 6'b000001;
    step();
    hw_int = '0;
    check("pulse_c1", cause_ip[2], 1'b0);
    step();
    check("pulse_c2", cause_ip[2], 1'b1);
    step();
    check("pulse_c3", cause_ip[2], 1'b0);

    hw_int = 6'b000001;
    repeat (3) step();
    check("prio_ip", cause_ip, 8'h84);
    status_im = 8'hFF; status_ie = 1'b1; status_exl = 1'b0;
    #1;
    check("prio_req", int_req, 1'b1);
    check("prio_num7", int_num, 3'd7);
    status_im = 8'h7F;
    #1;
    check("prio_num2", int_num, 3'd2);
    check("prio_req2", int_req, 1'b1);
    status_exl = 1'b1;
    #1;
    check("prio_exl", int_req, 1'b0);
    step();
    status_exl = 1'b0;
    status_im = 8'hFF;

    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 599) != 0);
      w_ena = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       w_addr = 8'h48;
        1:       w_addr = 8'h58;
        2:       w_addr = 8'h68;
        default: w_addr = 8'($urandom());
      endcase
      case ($urandom_range(0, 3))
        0:       w_data = m_count + 32'($urandom_range(0, 6));
        1:       w_data = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: w_data = $urandom();
      endcase
      case ($urandom_range(0, 3))
        0:       r_addr = 8'h48;
        1:       r_addr = 8'h58;
        2:       r_addr = 8'h68;
        default: r_addr = 8'($urandom());
      endcase
      if ($urandom_range(0, 3) == 0) hw_int = NHw'($urandom());
      if ($urandom_range(0, 7) == 0) status_im = 8'($urandom());
      status_ie  = ($urandom_range(0, 3) != 0);
      status_exl = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
